// File: rtl/dsp48_pkg.sv
// Shared widths, operand-select encodings and carry-in source names for the
// DSP48A1 post-adder/accumulator slice.
package dsp48_pkg;

  localparam int P_W = 48;
  localparam int M_W = 36;
  localparam int C_W = 48;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } xsel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } zsel_e;

  localparam string CIN_OPMODE5 = "OPMODE5";
  localparam string CIN_CARRYIN = "CARRYIN";

  // Fields of the opmode byte that the post-adder actually looks at.
  typedef struct packed {
    logic  sub;
    logic  cin5;
    zsel_e zsel;
    xsel_e xsel;
  } opm_t;

  function automatic opm_t opm_decode(input logic [7:0] opm);
    opm_t o;
    o.sub  = opm[7];
    o.cin5 = opm[5];
    o.zsel = zsel_e'(opm[3:2]);
    o.xsel = xsel_e'(opm[1:0]);
    return o;
  endfunction

endpackage

// File: rtl/dsp_post_adder_acc_reg.sv
// Optional pipeline register with bypass: SEL=1 presents the register,
// SEL=0 passes d straight through.
module dsp_post_adder_acc_reg #(
  parameter int    WIDTH   = 1,
  parameter int    SEL     = 1,
  parameter string RSTTYPE = "ASYNC"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  generate
    if (RSTTYPE == "ASYNC") begin : g_async
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     r_q <= '0;
        else if (ce) r_q <= d;
      end
    end else begin : g_sync
      always_ff @(posedge clk) begin
        if (rst)     r_q <= '0;
        else if (ce) r_q <= d;
      end
    end
  endgenerate

  assign q = (SEL != 0) ? r_q : d;

endmodule

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1 post-adder/accumulator: X/Z operand muxes, add/sub with carry-in,
// P register with carry-out and cascade output.
module dsp_post_adder_acc
  import dsp48_pkg::*;
#(
  parameter int    PREG       = 1,
  parameter int    OPMODEREG  = 1,
  parameter int    CARRYINREG = 1,
  parameter string CARRYINSEL = "OPMODE5"
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cep,
  input  logic           ceopmode,
  input  logic           cecarryin,
  input  logic [7:0]     opmode,
  input  logic [M_W-1:0] m,
  input  logic [P_W-1:0] dab,
  input  logic [C_W-1:0] c,
  input  logic [P_W-1:0] pcin,
  input  logic           carryin,
  output logic [P_W-1:0] p,
  output logic [P_W-1:0] pcout,
  output logic           carryout,
  output logic           carryoutf
);

  logic [7:0]     opm;
  opm_t           op;
  logic           csrc;
  logic           cin;
  logic [P_W-1:0] p_fb;
  logic [P_W-1:0] x_d;
  logic [P_W-1:0] z_d;
  logic [P_W:0]   sum_d;
  logic [P_W:0]   p_out;
  logic           unused_opm;

  dsp_post_adder_acc_reg #(.WIDTH(8), .SEL(OPMODEREG), .RSTTYPE("ASYNC")) u_opmode_reg (
    .clk (clk),
    .rst (rst),
    .ce  (ceopmode),
    .d   (opmode),
    .q   (opm)
  );

  assign op         = opm_decode(opm);
  assign unused_opm = ^{opm[6], opm[4]};

  // With a registered opmode the carry-in register samples the registered bit.
  assign csrc = (CARRYINSEL == CIN_OPMODE5) ? op.cin5 : carryin;

  dsp_post_adder_acc_reg #(.WIDTH(1), .SEL(CARRYINREG), .RSTTYPE("ASYNC")) u_cin_reg (
    .clk (clk),
    .rst (rst),
    .ce  (cecarryin),
    .d   (csrc),
    .q   (cin)
  );

  // Feedback only exists with a P register; without it the select is illegal.
  assign p_fb = (PREG != 0) ? p : 'x;

  always_comb begin
    x_d = '0;
    unique case (op.xsel)
      X_ZERO: x_d = '0;
      X_M:    x_d = {{(P_W-M_W){1'b0}}, m};
      X_P:    x_d = p_fb;
      X_DAB:  x_d = dab;
      default: x_d = '0;
    endcase
  end

  always_comb begin
    z_d = '0;
    unique case (op.zsel)
      Z_ZERO: z_d = '0;
      Z_PCIN: z_d = pcin;
      Z_P:    z_d = p_fb;
      Z_C:    z_d = c;
      default: z_d = '0;
    endcase
  end

  // Bit 48 is carry on add and borrow on subtract.
  always_comb begin
    sum_d = '0;
    if (op.sub) sum_d = {1'b0, z_d} - ({1'b0, x_d} + {{P_W{1'b0}}, cin});
    else        sum_d = {1'b0, z_d} + {1'b0, x_d} + {{P_W{1'b0}}, cin};
  end

  dsp_post_adder_acc_reg #(.WIDTH(P_W+1), .SEL(PREG), .RSTTYPE("ASYNC")) u_p_reg (
    .clk (clk),
    .rst (rst),
    .ce  (cep),
    .d   (sum_d),
    .q   (p_out)
  );

  assign {carryout, p} = p_out;
  assign pcout         = p;
  assign carryoutf     = carryout;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Directed bench: four parameterisations of the post-adder share one stimulus.
module tb_dsp_post_adder_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cep = 1'b1, ceopmode = 1'b1, cecarryin = 1'b1;
  logic [7:0]  opmode = 8'h00;
  logic [35:0] m = '0;
  logic [47:0] dab = '0, c = '0, pcin = '0;
  logic        carryin = 1'b0;

  // a: OPMODEREG=0 CARRYINREG=0 OPMODE5   b: all registered, OPMODE5
  // c: OPMODEREG=0 CARRYINREG=1 CARRYIN   d: PREG=0, fully combinational
  logic [47:0] p_a, pc_a, p_b, pc_b, p_c, pc_c, p_d, pc_d;
  logic        co_a, cf_a, co_b, cf_b, co_c, cf_c, co_d, cf_d;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dsp_post_adder_acc #(.PREG(1), .OPMODEREG(0), .CARRYINREG(0), .CARRYINSEL("OPMODE5")) u_a (
    .clk(clk), .rst(rst), .cep(cep), .ceopmode(ceopmode), .cecarryin(cecarryin),
    .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
    .p(p_a), .pcout(pc_a), .carryout(co_a), .carryoutf(cf_a));

  dsp_post_adder_acc #(.PREG(1), .OPMODEREG(1), .CARRYINREG(1), .CARRYINSEL("OPMODE5")) u_b (
    .clk(clk), .rst(rst), .cep(cep), .ceopmode(ceopmode), .cecarryin(cecarryin),
    .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
    .p(p_b), .pcout(pc_b), .carryout(co_b), .carryoutf(cf_b));

  dsp_post_adder_acc #(.PREG(1), .OPMODEREG(0), .CARRYINREG(1), .CARRYINSEL("CARRYIN")) u_c (
    .clk(clk), .rst(rst), .cep(cep), .ceopmode(ceopmode), .cecarryin(cecarryin),
    .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
    .p(p_c), .pcout(pc_c), .carryout(co_c), .carryoutf(cf_c));

  dsp_post_adder_acc #(.PREG(0), .OPMODEREG(0), .CARRYINREG(0), .CARRYINSEL("OPMODE5")) u_d (
    .clk(clk), .rst(rst), .cep(cep), .ceopmode(ceopmode), .cecarryin(cecarryin),
    .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
    .p(p_d), .pcout(pc_d), .carryout(co_d), .carryoutf(cf_d));

  task automatic chk(input string tag, input logic [48:0] obs, input logic [48:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_p_a",   {co_a, p_a},  49'd0);
    chk("rst_cf_a",  {48'd0, cf_a}, 49'd0);
    chk("rst_p_b",   {co_b, p_b},  49'd0);
    chk("rst_pc_c",  {co_c, pc_c}, 49'd0);
    rst = 1'b0;

    // load C, then async reset between edges
    opmode = 8'h0C; c = 48'h1234;
    #1;
    chk("comb_d_c", {co_d, p_d}, {1'b0, 48'h1234});
    tick();
    chk("load_c_a",  {co_a, p_a},  {1'b0, 48'h1234});
    chk("load_pc_a", {1'b0, pc_a}, {1'b0, 48'h1234});
    rst = 1'b1;
    #1;
    chk("async_rst_a", {co_a, p_a}, 49'd0);
    chk("async_rst_b", {co_b, p_b}, 49'd0);
    rst = 1'b0;

    // accumulate p <- p + m from reset
    opmode = 8'h09; m = 36'd5; c = '0;
    tick(); chk("acc1", {co_a, p_a}, 49'd5);
    tick(); chk("acc2", {co_a, p_a}, 49'd10);
    tick(); chk("acc3", {co_a, p_a}, 49'd15);
    tick(); chk("acc4", {co_a, p_a}, 49'd20);
    cep = 1'b0; m = 36'd9;
    tick(); tick();
    chk("acc_hold",    {co_a, p_a},  49'd20);
    chk("acc_hold_pc", {1'b0, pc_a}, 49'd20);

    // subtract with borrow: 3 - 5
    cep = 1'b1; opmode = 8'h8D; c = 48'd3; m = 36'd5;
    #1;
    chk("sub_comb_d", {co_d, p_d}, {1'b1, 48'hFFFF_FFFF_FFFE});
    tick();
    chk("sub_a",  {co_a, p_a}, {1'b1, 48'hFFFF_FFFF_FFFE});
    chk("sub_cf", {48'd0, cf_a}, 49'd1);
    cep = 1'b0; opmode = 8'h00; c = 48'd77;
    tick();
    chk("sub_hold", {co_a, p_a}, {1'b1, 48'hFFFF_FFFF_FFFE});
    cep = 1'b1;

    // overflow via opmode[5] carry-in
    opmode = 8'h2F; c = 48'hFFFF_FFFF_FFFF; dab = '0;
    #1;
    chk("ovf_comb_d", {co_d, p_d}, {1'b1, 48'd0});
    tick();
    chk("ovf_a", {co_a, p_a}, {1'b1, 48'd0});

    // plain add of C and DAB, no carry
    opmode = 8'h0F; c = 48'd10; dab = 48'h123;
    #1;
    chk("add_dab_d", {co_d, p_d}, {1'b0, 48'h12D});
    tick();
    chk("add_dab_a", {co_a, p_a}, {1'b0, 48'h12D});

    // registered opmode: C then PCIN, with one cycle of extra latency
    opmode = 8'h0C; c = 48'h1111; pcin = 48'hABCD;
    tick(); tick(); tick();
    chk("casc_c_b", {co_b, p_b}, {1'b0, 48'h1111});
    opmode = 8'h04;
    tick();
    chk("casc_lag_b",  {co_b, p_b},  {1'b0, 48'h1111});
    chk("casc_lag_pc", {1'b0, pc_b}, {1'b0, 48'h1111});
    tick();
    chk("casc_pcin_b",  {co_b, p_b},  {1'b0, 48'hABCD});
    chk("casc_pcin_pc", {1'b0, pc_b}, {1'b0, 48'hABCD});

    // external registered carry-in
    opmode = 8'h00; carryin = 1'b0;
    tick(); tick();
    chk("cin_zero_c", {co_c, p_c}, 49'd0);
    carryin = 1'b1;
    tick();
    chk("cin_lag_c", {co_c, p_c}, 49'd0);
    tick();
    chk("cin_one_c",  {co_c, p_c},  49'd1);
    chk("cin_one_pc", {1'b0, pc_c}, 49'd1);
    cecarryin = 1'b0; carryin = 1'b0;
    tick(); tick();
    chk("cin_hold_c", {co_c, p_c}, 49'd1);
    cecarryin = 1'b1;
    tick(); tick();
    chk("cin_clear_c", {co_c, p_c}, 49'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
